// File: rtl/pulse_cfg_scheduler_pkg.sv
// Shared opcode, error-code and state definitions for the pulse channel command front-end.
// Opcodes and error codes travel over SPI, so their encodings are fixed.
package pulse_cfg_scheduler_pkg;
  localparam int CONF_HIGH_W = 24;
  localparam int CONF_LOW_W  = 40;
  localparam int CONF_W      = CONF_HIGH_W + CONF_LOW_W;

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_WRITE    = 4'h1;
  localparam logic [3:0] OP_START    = 4'h2;
  localparam logic [3:0] OP_STOP     = 4'h3;
  localparam logic [3:0] OP_STOP_ALL = 4'hF;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_DECODE = 2'b01;
  localparam logic [1:0] ERR_UNCONF = 2'b10;
  localparam logic [1:0] ERR_FRAME  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  function automatic logic op_known(input logic [3:0] op);
    return (op == OP_NOP) || (op == OP_WRITE) || (op == OP_START) ||
           (op == OP_STOP) || (op == OP_STOP_ALL);
  endfunction
endpackage

// File: rtl/pulse_cfg_scheduler_if.sv
// Config-word valid/ready port between the command front-end and the channel bank.
interface pulse_cfg_scheduler_if #(parameter int CH_W = 2);
  import pulse_cfg_scheduler_pkg::*;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_chan;
  logic [CONF_W-1:0] cfg_word;

  modport master (output cfg_valid, cfg_chan, cfg_word, input cfg_ready);
  modport slave  (input cfg_valid, cfg_chan, cfg_word, output cfg_ready);
endinterface

// File: rtl/pulse_cfg_scheduler.sv
// Decodes framed SPI command bytes, loads 64-bit HIGH/LOW words into channels and owns
// each channel's run bit. Errors surface as a one-cycle strobe with a code.
module pulse_cfg_scheduler
  import pulse_cfg_scheduler_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte,
  input  logic                  i_frame_end,
  pulse_cfg_scheduler_if.master cfg,
  output logic [N_CH-1:0]       o_start_nstop,
  output logic [N_CH-1:0]       o_configured,
  output logic                  o_err,
  output logic [1:0]            o_err_code,
  output logic                  o_busy
);
  state_e            state_q, state_d;
  logic [CONF_W-1:0] word_q, word_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic [N_CH-1:0]   run_q, run_d;
  logic [N_CH-1:0]   conf_q, conf_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic [3:0]      hdr_op;
  logic [CH_W-1:0] hdr_idx;
  logic            hdr_ch_ok;

  assign hdr_op    = i_byte[7:4];
  assign hdr_idx   = CH_W'(i_byte[3:0]);
  assign hdr_ch_ok = {1'b0, i_byte[3:0]} < 5'(N_CH);

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    chan_d     = chan_q;
    run_d      = run_q;
    conf_d     = conf_q;
    err_code_d = ERR_NONE;
    unique case (state_q)
      ST_IDLE: begin
        if (i_byte_valid) begin
          // STOP_ALL carries no channel, so its low nibble is never range-checked.
          if (!op_known(hdr_op) || (hdr_op != OP_STOP_ALL && !hdr_ch_ok)) begin
            err_code_d = ERR_DECODE;
            state_d    = ST_DRAIN;
          end else begin
            case (hdr_op)
              OP_WRITE: begin
                cnt_d   = 3'd0;
                chan_d  = hdr_idx;
                state_d = ST_COLLECT;
              end
              OP_START: begin
                if (conf_q[hdr_idx]) run_d[hdr_idx] = 1'b1;
                else                 err_code_d     = ERR_UNCONF;
              end
              OP_STOP:     run_d[hdr_idx] = 1'b0;
              OP_STOP_ALL: run_d          = '0;
              default: ;
            endcase
          end
        end
      end
      ST_COLLECT: begin
        if (i_byte_valid) begin
          word_d = {word_q[CONF_W-9:0], i_byte};
          cnt_d  = cnt_q + 3'd1;
        end
        if (i_byte_valid && cnt_q == 3'd7) begin
          // A channel is never left running on a half-updated configuration.
          run_d[chan_q] = 1'b0;
          state_d       = ST_COMMIT;
        end else if (i_frame_end) begin
          err_code_d = ERR_FRAME;
          state_d    = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        if (i_byte_valid) err_code_d = ERR_FRAME;
        if (cfg.cfg_ready) begin
          conf_d[chan_q] = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (i_frame_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    err_d = (err_code_d != ERR_NONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      cnt_q      <= '0;
      chan_q     <= '0;
      run_q      <= '0;
      conf_q     <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      chan_q     <= chan_d;
      run_q      <= run_d;
      conf_q     <= conf_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign cfg.cfg_valid = (state_q == ST_COMMIT);
  assign cfg.cfg_chan  = chan_q;
  assign cfg.cfg_word  = word_q;
  assign o_start_nstop = run_q;
  assign o_configured  = conf_q;
  assign o_err         = err_q;
  assign o_err_code    = err_code_q;
  assign o_busy        = (state_q != ST_IDLE);
endmodule
